// File: rtl/aucohl_serial_tx.sv
// aucohl_serial_tx: UART-style transmitter draining an aucohl_fifo read port.
// Frame = start bit, DW data bits LSB-first, optional parity, one or two stop bits.
// Bit period is clk_div+1 clocks; all frame config is captured on the fetch edge.
module aucohl_serial_tx #(
  parameter int unsigned DW = 8,
  parameter int unsigned W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  clk_div,
  input  logic          parity_en,
  input  logic          parity_odd,
  input  logic          two_stop,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rdata,
  output logic          fifo_rd,
  output logic          tx,
  output logic          busy,
  output logic          done
);

  localparam int unsigned BCW = $clog2(DW + 1);
  localparam logic [BCW-1:0] LastBit = BCW'(DW - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e         state_q;
  logic [W-1:0]   baud_q;
  logic [W-1:0]   div_q;
  logic [BCW-1:0] bit_q;
  logic [DW-1:0]  shift_q;
  logic           par_en_q;
  logic           two_stop_q;
  logic           par_q;
  logic           tx_q;
  logic           done_q;
  logic           bit_end;

  assign bit_end = (baud_q == '0);

  // Pop only from IDLE; rst term keeps the strobe quiet during an async reset.
  assign fifo_rd = (state_q == StIdle) & en & ~fifo_empty & ~rst;
  assign busy    = (state_q != StIdle);
  assign tx      = tx_q;
  assign done    = done_q;

  // Frame sequencer: fetch, bit timing, serial shift and registered tx/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Baud counter runs only inside a frame and reloads at every bit end.
      if (state_q != StIdle) begin
        baud_q <= bit_end ? div_q : baud_q - 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (fifo_rd) begin
            shift_q    <= fifo_rdata;
            div_q      <= clk_div;
            par_en_q   <= parity_en;
            two_stop_q <= two_stop;
            par_q      <= (^fifo_rdata) ^ parity_odd;
            baud_q     <= clk_div;
            bit_q      <= '0;
            tx_q       <= 1'b0;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_q == LastBit) begin
              bit_q <= '0;
              if (par_en_q) begin
                tx_q    <= par_q;
                state_q <= StParity;
              end else begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            bit_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (bit_end) begin
            // bit_q counts completed stop bits when two are configured.
            if (two_stop_q && (bit_q == '0)) begin
              bit_q <= BCW'(1);
            end else begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aucohl_serial_tx.sv
// Directed bench for aucohl_serial_tx with a small FIFO model on the read port.
module tb_aucohl_serial_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] clk_div;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_rd;
  logic        tx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_fetch;

  logic [7:0] mem [32];
  logic [4:0] wr_ptr = '0;
  logic [4:0] rd_ptr = '0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = mem[rd_ptr];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) rd_ptr <= rd_ptr + 5'd1;
  end

  aucohl_serial_tx #(.DW(8), .W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clk_div    (clk_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Waits for the fetch, then checks every clock of the frame and the done cycle.
  // par_bit is the hand-computed parity value for the byte.
  task automatic frame(input string tag, input logic [7:0] data, input int div,
                       input bit par_en, input bit par_bit, input bit two);
    logic [12:0] seq;
    int          n;
    int          idx;
    #1;
    for (int i = 0; i < 100 && fifo_rd !== 1'b1; i++) step();
    check_eq({tag, " fetch"}, 32'(fifo_rd), 32'd1);
    if (fifo_rd !== 1'b1) return;
    last_fetch = cyc;
    seq = '1;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[1 + i] = data[i];
    idx = 9;
    if (par_en) begin
      seq[9] = par_bit;
      idx = 10;
    end
    n = idx + 1 + int'(two);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c <= div; c++) begin
        step();
        check_eq($sformatf("%s tx b%0d c%0d", tag, b, c), 32'(tx), 32'(seq[b]));
        check_eq($sformatf("%s busy b%0d", tag, b), 32'(busy), 32'd1);
        check_eq($sformatf("%s done b%0d", tag, b), 32'(done), 32'd0);
        check_eq($sformatf("%s rd b%0d", tag, b), 32'(fifo_rd), 32'd0);
      end
    end
    step();
    check_eq({tag, " done"}, 32'(done), 32'd1);
    check_eq({tag, " busy end"}, 32'(busy), 32'd0);
    check_eq({tag, " tx end"}, 32'(tx), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int f1;
    int f2;
    rst = 1'b1;
    en = 1'b1;
    clk_div = 16'd3;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    two_stop = 1'b0;
    #3;
    push(8'hA5);
    #1;
    check_eq("rst tx", 32'(tx), 32'd1);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst rd", 32'(fifo_rd), 32'd0);
    step();
    step();
    rst = 1'b0;

    // Single byte 0xA5, 4 clocks per bit.
    frame("a5", 8'hA5, 3, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("a5 done once", 32'(done), 32'd0);
    check_eq("a5 tx idle", 32'(tx), 32'd1);

    // Parity: 0x07 has three ones -> even parity bit 1, odd parity bit 0.
    clk_div = 16'd1;
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push(8'h07);
    frame("par_even", 8'h07, 1, 1'b1, 1'b1, 1'b0);
    parity_odd = 1'b1;
    push(8'h07);
    frame("par_odd", 8'h07, 1, 1'b1, 1'b0, 1'b0);
    parity_odd = 1'b0;
    two_stop = 1'b1;
    push(8'h07);
    frame("par_2stop", 8'h07, 1, 1'b1, 1'b1, 1'b1);

    // Enable gating.
    parity_en = 1'b0;
    two_stop = 1'b0;
    en = 1'b0;
    push(8'h55);
    push(8'h66);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq("en0 idle", 32'(bad), 32'd0);
    en = 1'b1;
    fork
      frame("en_drop", 8'h55, 1, 1'b0, 1'b0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        en = 1'b0;
      end
    join
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fifo_rd !== 1'b0 || tx !== 1'b1) bad++;
    end
    check_eq("en0 no fetch", 32'(bad), 32'd0);
    en = 1'b1;
    frame("en_again", 8'h66, 1, 1'b0, 1'b0, 1'b0);

    // Config changes mid-frame only affect the next frame.
    clk_div = 16'd3;
    parity_en = 1'b0;
    two_stop = 1'b0;
    parity_odd = 1'b0;
    push(8'h81);
    push(8'h07);
    fork
      frame("cfg1", 8'h81, 3, 1'b0, 1'b0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        clk_div = 16'd0;
        parity_en = 1'b1;
        two_stop = 1'b1;
      end
    join
    frame("cfg2", 8'h07, 0, 1'b1, 1'b1, 1'b1);

    // Back-to-back frames at one clock per bit.
    parity_en = 1'b0;
    two_stop = 1'b0;
    en = 1'b0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    step();
    en = 1'b1;
    frame("b2b1", 8'h01, 0, 1'b0, 1'b0, 1'b0);
    f1 = last_fetch;
    frame("b2b2", 8'h02, 0, 1'b0, 1'b0, 1'b0);
    f2 = last_fetch;
    check_eq("b2b gap12", 32'(f2 - f1), 32'd11);
    frame("b2b3", 8'h03, 0, 1'b0, 1'b0, 1'b0);
    check_eq("b2b gap23", 32'(last_fetch - f2), 32'd11);

    // Reset during data bit 4 of 0x0F (bit 4 is 0).
    clk_div = 16'd3;
    push(8'h0F);
    push(8'h3C);
    #1;
    for (int i = 0; i < 100 && fifo_rd !== 1'b1; i++) step();
    check_eq("rstmid fetch", 32'(fifo_rd), 32'd1);
    repeat (22) step();
    check_eq("rstmid tx pre", 32'(tx), 32'd0);
    check_eq("rstmid busy pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rstmid tx", 32'(tx), 32'd1);
    check_eq("rstmid busy", 32'(busy), 32'd0);
    check_eq("rstmid done", 32'(done), 32'd0);
    check_eq("rstmid rd", 32'(fifo_rd), 32'd0);
    step();
    check_eq("rstmid rd held", 32'(fifo_rd), 32'd0);
    check_eq("rstmid done held", 32'(done), 32'd0);
    rst = 1'b0;
    frame("after_rst", 8'h3C, 3, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
